riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RISC-V core with cache-backed memory.
- Decodes opcode and sequences FETCH, DECODE, EXECUTE, MEM and WB.
- Produces ALUOp plus the funct3/op5/funct7b5 fields consumed by alu_control, so it is the upstream driver of that interface.
- Stalls on a req/ready handshake with the cache for instruction fetch, load and store.

Parameters:
- ILLEGAL_TRAP, 1, 1: an unknown opcode enters sticky HALT. 0: an unknown opcode is treated as NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- mem_ready  in  1  cache completes the current access this cycle
- mem_req  out  1  cache access request
- mem_write  out  1  store strobe, qualifies mem_req
- adr_src  out  1  0 = PC, 1 = Result
- ir_write  out  1  load the instruction register
- pc_update  out  1  unconditional PC write
- branch  out  1  PC write if Zero
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_op  out  2  to alu_control
- funct3_o  out  3  = funct3, combinational
- op5_o  out  1  = op[5], combinational
- funct7b5_o  out  1  = funct7b5, combinational
- illegal_instr  out  1  1-cycle pulse on an unknown opcode in DECODE
- halted  out  1  high while in HALT

Behaviour:
- State register resets asynchronously to RST.
- In RST all outputs except the pass-throughs and imm_src are 0. Unconditional move to FETCH on the next edge.
- Outputs are Moore on state, except the FETCH/MEMREAD/MEMWRITE strobes and transitions, which are qualified by mem_ready.
- imm_src decodes op combinationally: 0010011/0000011 = 00, 0100011 = 01, 1100011 = 10, 1101111 = 11, else 00.
- Any field not listed in a state below is 0.
- FETCH:
  - Always: mem_req = 1, adr_src = 0.
  - If mem_ready: ir_write = 1, pc_update = 1, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10, and go to DECODE.
  - Else hold in FETCH with ir_write and pc_update at 0.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00. Next state by op:
  - lw/sw: MEMADR
  - 0110011: EXECR
  - 0010011: EXECI
  - 1100011: BEQ
  - 1101111: JAL
  - other: pulse illegal_instr, then HALT if ILLEGAL_TRAP = 1, else FETCH.
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next: MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Go to MEMWB on mem_ready, else hold.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1, result_src = 00. All held until mem_ready, then go to FETCH.
- MEMWB: result_src = 01, reg_write = 1. Next: FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next: ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next: ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next: FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1. Next: FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. Next: ALUWB.
- HALT: all strobes 0, halted = 1. Sticky until rst_n is asserted.
- Latency with zero-wait memory, in cycles from FETCH entry to the next FETCH: R/I = 4, lw = 5, sw = 4, beq = 3, jal = 4. Each stall cycle adds 1.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- mem_req is never high in two different access states without an intervening non-access state, except the MEMWRITE to FETCH back-to-back transition.
- rst_n low mid-operation returns to RST immediately. mem_req drops in the same cycle, asynchronously.
- There is never more than one of reg_write, mem_write or ir_write high per cycle.

Test Plan:
- Release reset, mem_ready = 1, op = 0110011, funct3 = 000, funct7b5 = 1.
  - Required: RST, FETCH (ir_write = 1), DECODE, EXECR (alu_op = 10, op5_o = 1, funct7b5_o = 1), ALUWB (reg_write = 1), FETCH.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD.
  - Required: mem_req = 1 and adr_src = 1 held 4 cycles, then MEMWB with result_src = 01 and reg_write = 1.
- sw (0100011) with mem_ready = 0 for 2 cycles.
  - Required: mem_write = 1 for 3 cycles, imm_src = 01, reg_write never asserted.
- beq (1100011) in DECODE, then jal (1101111) in DECODE.
  - Required for beq: BEQ state with alu_op = 01, branch = 1, imm_src = 10, next state FETCH.
  - Required for jal: JAL state with pc_update = 1, alu_src_b = 10, then ALUWB with reg_write = 1.
- op = 1111111.
  - Required: illegal_instr pulses 1 cycle. halted = 1 persists with ILLEGAL_TRAP = 1. With ILLEGAL_TRAP = 0, the FSM returns to FETCH.
- Assert rst_n low during a MEMWRITE stall.
  - Required: mem_req and mem_write go to 0 immediately. After release, the first FETCH follows the RST cycle.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/memory/writeback.
// Latency: Moore outputs off the state register; R/I/sw/jal 4 cycles, lw 5, beq 3 per instruction.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their request until mem_ready; other states ignore it.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   mem_ready             cache completes the current access this cycle
//   mem_req, mem_write    cache request and store strobe (mem_write qualifies mem_req)
//   adr_src               memory address select (0 = PC, 1 = Result)
//   ir_write, pc_update, branch, reg_write   architectural state write enables
//   alu_src_a, alu_src_b, result_src, imm_src datapath mux selects
//   alu_op, funct3_o, op5_o, funct7b5_o       fields for the downstream alu_control
//   illegal_instr         1-cycle pulse on an unknown opcode in DECODE
//   halted                high while in the sticky HALT state
module riscv_multicycle_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_op,
    output logic [2:0] funct3_o,
    output logic       op5_o,
    output logic       funct7b5_o,
    output logic       illegal_instr,
    output logic       halted
);

    // Opcodes understood by this controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Datapath mux encodings
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWRITE = 4'd5,
        S_MEMWB    = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   op_known;

    always_comb begin
        op_known = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    // State register. Outputs decode from this, so reset drops every
    // strobe (mem_req included) asynchronously with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BEQ;
                    OP_JAL:            state_nxt = S_JAL;
                    default:           state_nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            // op[5] separates store (0100011) from load (0000011)
            S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_MEMWB:    state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_RST;
        endcase
    end

    // Output logic. Moore on state except FETCH, whose IR/PC writes only
    // happen in the cycle the cache returns the instruction.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = ADR_PC;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                adr_src = ADR_PC;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALUOP_ADD;
                    result_src = RES_ALURESULT;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target from OldPC + imm
                alu_src_a     = SRCA_OLDPC;
                alu_src_b     = SRCB_IMM;
                alu_op        = ALUOP_ADD;
                illegal_instr = ~op_known;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = ADR_RESULT;
                result_src = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = ADR_RESULT;
                result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
            end
            S_JAL: begin
                // Link value OldPC + 4 is computed here; ALUOut still holds
                // the target from DECODE and drives the PC write.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Immediate format follows the opcode in every state, including RST
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_ITYPE, OP_LOAD: imm_src = IMM_I;
            OP_STORE:          imm_src = IMM_S;
            OP_BRANCH:         imm_src = IMM_B;
            OP_JAL:            imm_src = IMM_J;
            default:           imm_src = IMM_I;
        endcase
    end

    // Fields forwarded untouched to alu_control
    assign funct3_o   = funct3;
    assign op5_o      = op[5];
    assign funct7b5_o = funct7b5;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: two instances (trap and no-trap) driven with the same vectors,
// checked every cycle against a per-instruction step-sequence model plus hand-computed literals.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       mem_ready;

    // Per-instance outputs: index 0 = ILLEGAL_TRAP 1, index 1 = ILLEGAL_TRAP 0
    logic       mem_req [2], mem_write [2], adr_src [2], ir_write [2], pc_update [2];
    logic       branch [2], reg_write [2], op5_o [2], funct7b5_o [2], illegal_instr [2], halted [2];
    logic [1:0] alu_src_a [2], alu_src_b [2], result_src [2], imm_src [2], alu_op [2];
    logic [2:0] funct3_o [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) u_dut_trap (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .mem_ready(mem_ready), .mem_req(mem_req[0]), .mem_write(mem_write[0]),
        .adr_src(adr_src[0]), .ir_write(ir_write[0]), .pc_update(pc_update[0]),
        .branch(branch[0]), .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]),
        .alu_src_b(alu_src_b[0]), .result_src(result_src[0]), .imm_src(imm_src[0]),
        .alu_op(alu_op[0]), .funct3_o(funct3_o[0]), .op5_o(op5_o[0]),
        .funct7b5_o(funct7b5_o[0]), .illegal_instr(illegal_instr[0]), .halted(halted[0])
    );

    riscv_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) u_dut_nop (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .mem_ready(mem_ready), .mem_req(mem_req[1]), .mem_write(mem_write[1]),
        .adr_src(adr_src[1]), .ir_write(ir_write[1]), .pc_update(pc_update[1]),
        .branch(branch[1]), .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]),
        .alu_src_b(alu_src_b[1]), .result_src(result_src[1]), .imm_src(imm_src[1]),
        .alu_op(alu_op[1]), .funct3_o(funct3_o[1]), .op5_o(op5_o[1]),
        .funct7b5_o(funct7b5_o[1]), .illegal_instr(illegal_instr[1]), .halted(halted[1])
    );

    // ---------------- reference model ----------------
    // The model thinks in instruction plans: after FETCH and DECODE every
    // instruction class runs a fixed list of steps, then fetches again.
    typedef enum {
        M_RST, M_FETCH, M_DECODE, M_MEMADR, M_MEMREAD, M_MEMWRITE, M_MEMWB,
        M_EXECR, M_EXECI, M_ALUWB, M_BEQ, M_JAL, M_HALT
    } step_e;

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write;
        logic [1:0] a, b, rs, imm, aop;
        logic [2:0] f3;
        logic       op5, f7b5, illegal, halted;
    } obs_t;

    function automatic int plan_len(input logic [6:0] o, input bit trap);
        case (o)
            RT, IT, SW, JAL: return 2;
            LW:              return 3;
            BEQ:             return 1;
            default:         return trap ? 1 : 0;
        endcase
    endfunction

    function automatic step_e plan_step(input logic [6:0] o, input int i);
        step_e s [3];
        s = '{M_HALT, M_HALT, M_HALT};
        case (o)
            RT:  s = '{M_EXECR,  M_ALUWB,    M_HALT};
            IT:  s = '{M_EXECI,  M_ALUWB,    M_HALT};
            LW:  s = '{M_MEMADR, M_MEMREAD,  M_MEMWB};
            SW:  s = '{M_MEMADR, M_MEMWRITE, M_HALT};
            BEQ: s = '{M_BEQ,    M_HALT,     M_HALT};
            JAL: s = '{M_JAL,    M_ALUWB,    M_HALT};
            default: s = '{M_HALT, M_HALT, M_HALT};
        endcase
        return s[i];
    endfunction

    function automatic obs_t expect_of(input step_e s, input logic rdy, input logic [6:0] o,
                                       input logic [2:0] f3, input logic f7);
        obs_t e;
        e = '0;
        e.f3   = f3;
        e.op5  = o[5];
        e.f7b5 = f7;
        e.imm  = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        case (s)
            M_FETCH: begin
                e.mem_req = 1'b1;
                if (rdy) begin
                    e.ir_write = 1'b1; e.pc_update = 1'b1; e.b = 2'b10; e.rs = 2'b10;
                end
            end
            M_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.illegal = (plan_len(o, 1'b0) == 0); end
            M_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
            M_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            M_MEMWRITE: begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; end
            M_MEMWB:    begin e.rs = 2'b01; e.reg_write = 1'b1; end
            M_EXECR:    begin e.a = 2'b10; e.aop = 2'b10; end
            M_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            M_ALUWB:    e.reg_write = 1'b1;
            M_BEQ:      begin e.a = 2'b10; e.aop = 2'b01; e.branch = 1'b1; end
            M_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.pc_update = 1'b1; end
            M_HALT:     e.halted = 1'b1;
            default:    ;
        endcase
        return e;
    endfunction

    step_e cur [2] = '{M_RST, M_RST};
    int    idx [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cur[k] <= M_RST;
                idx[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (cur[k])
                    M_RST:    cur[k] <= M_FETCH;
                    M_HALT:   ;
                    M_FETCH:  if (mem_ready) cur[k] <= M_DECODE;
                    M_DECODE: begin
                        if (plan_len(op, k == 0) == 0) begin
                            cur[k] <= M_FETCH;
                        end else begin
                            cur[k] <= plan_step(op, 0);
                            idx[k] <= 1;
                        end
                    end
                    default: begin
                        if ((cur[k] == M_MEMREAD || cur[k] == M_MEMWRITE) && !mem_ready) begin
                            cur[k] <= cur[k];
                        end else if (idx[k] < plan_len(op, k == 0)) begin
                            cur[k] <= plan_step(op, idx[k]);
                            idx[k] <= idx[k] + 1;
                        end else begin
                            cur[k] <= M_FETCH;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            obs_t got;
            obs_t exp_o;
            got = {mem_req[k], mem_write[k], adr_src[k], ir_write[k], pc_update[k], branch[k],
                   reg_write[k], alu_src_a[k], alu_src_b[k], result_src[k], imm_src[k],
                   alu_op[k], funct3_o[k], op5_o[k], funct7b5_o[k], illegal_instr[k], halted[k]};
            exp_o = expect_of(cur[k], mem_ready, op, funct3, funct7b5);
            n_chk++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL model_cycle inst%0d cyc=%0d step=%s: got %h required %h",
                         k, cyc, cur[k].name(), got, exp_o);
            end
            n_chk++;
            if ((32'(reg_write[k]) + 32'(mem_write[k]) + 32'(ir_write[k])) > 1) begin
                n_fail++;
                $display("FAIL write_exclusive inst%0d cyc=%0d: got rw=%b mw=%b iw=%b required at most one",
                         k, cyc, reg_write[k], mem_write[k], ir_write[k]);
            end
        end
    end

    // ---------------- directed stimulus with literal checks ----------------
    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h required %0h", nm, cyc, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; op = RT; funct3 = 3'b000; funct7b5 = 1'b1;
        #2;
        chk("rst_mem_req", 8'(mem_req[0]), 8'd0);
        chk("rst_alu_op",  8'(alu_op[0]), 8'd0);
        chk("rst_halted",  8'(halted[0]), 8'd0);
        repeat (2) tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        tick();                                        // FETCH
        chk("r_fetch_ir_write", 8'(ir_write[0]), 8'd1);
        chk("r_fetch_mem_req",  8'(mem_req[0]), 8'd1);
        tick();                                        // DECODE
        chk("r_decode_src_a", 8'(alu_src_a[0]), 8'd1);
        tick();                                        // EXECR
        chk("r_exec_alu_op", 8'(alu_op[0]), 8'd2);
        chk("r_exec_op5",    8'(op5_o[0]), 8'd1);
        chk("r_exec_f7b5",   8'(funct7b5_o[0]), 8'd1);
        tick();                                        // ALUWB
        chk("r_aluwb_reg_write", 8'(reg_write[0]), 8'd1);
        tick();                                        // FETCH
        chk("r_next_fetch", 8'(mem_req[0]), 8'd1);

        op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
        tick();                                        // DECODE
        tick();                                        // MEMADR
        mem_ready = 1'b0;
        tick();                                        // MEMREAD, 3 stall cycles then ready
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("lw_memread_req_adr", 8'(mem_req[0] & adr_src[0]), 8'd1);
            tick();
        end
        chk("lw_memwb_result_src", 8'(result_src[0]), 8'd1);
        chk("lw_memwb_reg_write",  8'(reg_write[0]), 8'd1);
        tick();                                        // FETCH

        op = SW;
        tick();                                        // DECODE
        tick();                                        // MEMADR
        mem_ready = 1'b0;
        tick();                                        // MEMWRITE, 2 stall cycles then ready
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            #1;
            chk("sw_mem_write", 8'(mem_write[0]), 8'd1);
            chk("sw_imm_src",   8'(imm_src[0]), 8'd1);
            chk("sw_no_reg_write", 8'(reg_write[0]), 8'd0);
            tick();
        end

        // FETCH with one stall cycle
        mem_ready = 1'b0; op = BEQ;
        #1;
        chk("fetch_stall_ir_write", 8'(ir_write[0]), 8'd0);
        chk("fetch_stall_mem_req",  8'(mem_req[0]), 8'd1);
        tick();
        mem_ready = 1'b1;
        tick();                                        // DECODE
        tick();                                        // BEQ
        chk("beq_alu_op",  8'(alu_op[0]), 8'd1);
        chk("beq_branch",  8'(branch[0]), 8'd1);
        chk("beq_imm_src", 8'(imm_src[0]), 8'd2);
        tick();                                        // FETCH
        chk("beq_then_fetch", 8'(mem_req[0]), 8'd1);

        op = JAL;
        tick();                                        // DECODE
        tick();                                        // JAL
        chk("jal_pc_update", 8'(pc_update[0]), 8'd1);
        chk("jal_src_b",     8'(alu_src_b[0]), 8'd2);
        tick();                                        // ALUWB
        chk("jal_aluwb_reg_write", 8'(reg_write[0]), 8'd1);
        tick();                                        // FETCH

        op = BAD;
        tick();                                        // DECODE
        chk("illegal_pulse_trap", 8'(illegal_instr[0]), 8'd1);
        chk("illegal_pulse_nop",  8'(illegal_instr[1]), 8'd1);
        tick();
        chk("illegal_one_cycle", 8'(illegal_instr[0]), 8'd0);
        chk("trap_halted",       8'(halted[0]), 8'd1);
        chk("nop_back_to_fetch", 8'(mem_req[1]), 8'd1);
        repeat (3) tick();
        chk("trap_halt_sticky", 8'(halted[0]), 8'd1);

        // Reset in the middle of a stalled store
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; op = SW;
        tick();                                        // FETCH
        tick();                                        // DECODE
        tick();                                        // MEMADR
        mem_ready = 1'b0;
        tick();                                        // MEMWRITE
        chk("sw2_mem_write", 8'(mem_write[0]), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req",   8'(mem_req[0]), 8'd0);
        chk("async_rst_mem_write", 8'(mem_write[0]), 8'd0);
        tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("post_rst_idle", 8'(mem_req[0]), 8'd0);
        tick();                                        // FETCH
        chk("post_rst_fetch", 8'(ir_write[0]), 8'd1);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
